aes_spi_slave_if: RTL and testbench
===================================

// Module: aes_spi_slave_if
// PURPOSE
//  SPI responder side of the AES serial link. Shifts in one DATA_W-bit block MSB-first on SDI while CS is high,
//  hands it to the attached AES core (cipher or inverse cipher) with a start/done handshake,
//  then shifts the core result out MSB-first on SDO. One instance per core.
//  Runs on the SPI bit clock supplied by the master. Master drives SDI on the falling edge; this block samples on the rising edge.
// PARAMETERS
//  DATA_W   128  block width in bits (>=2)
//  TIMEOUT  64   max cycles in WAIT for core_done before abort (>=2)
// PORTS
//  clk          in   1       SPI bit clock; all logic on posedge
//  rst          in   1       synchronous, active-high reset; priority over all other inputs
//  CS           in   1       chip select, active high; frames only while high
//  SDI          in   1       serial data from master (MOSI)
//  SDO          out  1       serial data to master (MISO), registered
//  sdo_valid    out  1       high during the DATA_W cycles in which SDO carries result bits
//  frame_done   out  1       1-cycle pulse after the last result bit
//  err          out  1       1-cycle pulse on core timeout
//  core_start   out  1       1-cycle start pulse to AES core
//  core_block   out  DATA_W  received block; stable from core_start until leaving WAIT
//  core_result  in   DATA_W  AES core output; sampled when core_done=1
//  core_done    in   1       AES core completion, sampled in WAIT only
// BEHAVIOUR
//  Reset: state=IDLE; SDO, sdo_valid, frame_done, err, core_start=0; core_block, shift regs, counters=0.
//  States: IDLE, RECV, START, WAIT, SEND.
//  IDLE: CS=1 -> shift_in<={shift_in[DATA_W-2:0],SDI} (first bit = MSB), bit_cnt<=1, go RECV.
//  RECV: each cycle with CS=1 shift SDI in and increment bit_cnt. The cycle that samples bit DATA_W-1 -> START.
//  START: core_block<=shift_in, core_start=1 for this cycle only, to_cnt<=0, go WAIT. core_done ignored here.
//  WAIT: core_done=1 -> shift_out<=core_result, SDO<=core_result[DATA_W-1], sdo_valid<=1, bit_cnt<=0, go SEND.
//        Otherwise to_cnt++. Reaching TIMEOUT-1 without done -> err pulse, go IDLE.
//        core_done and timeout in the same cycle: done wins, no err.
//  SEND: SDO holds result bit k (MSB=k0) during SEND cycle k, k=0..DATA_W-1. Each cycle shift_out shifts left.
//        SDO<=next bit. At k=DATA_W-1: SDO<=0, sdo_valid<=0, frame_done pulse, go IDLE.
//  Latency: first SDI bit sampled at cycle 0; core_start high at cycle DATA_W.
//   First SDO bit is valid the cycle after core_done is sampled.
//   Total frame = DATA_W + 1 + core_latency + DATA_W cycles.
//  CS low in RECV: abort to IDLE, bit_cnt<=0, no core_start. A partial block is never forwarded.
//  CS low in START/WAIT/SEND: ignored; transaction completes (CS gates reception only).
//  Back-to-back: IDLE with CS=1 on the cycle after frame_done starts the next frame immediately.
//  rst mid-frame: all outputs to reset values on the next posedge; any core_done in flight is discarded.
//  Outside SEND, SDO=0 and sdo_valid=0 at all times.
//  frame_done, err, and core_start are never high in the same cycle.
// TESTING
//  T1 reset: hold rst 3 cycles with CS=1, SDI=1 -> all outputs 0, state IDLE, no core_start.
//  T2 FIPS-197 vector: shift 128'h00112233445566778899aabbccddeeff.
//     Core model returns 128'h69c4e0d86a7b0430d8cdb78070b4c55a 10 cycles after start.
//     -> core_start at cycle 128 with core_block equal to the input.
//     -> SDO serial equals the result over 128 sdo_valid cycles, then frame_done pulse.
//  T3 CS abort: drop CS after bit 60 -> no core_start; next full frame gives the correct block and result.
//  T4 timeout: core_done held 0 -> err pulse at cycle TIMEOUT-1 in WAIT; back in IDLE; SDO stays 0.
//     Also: core_done rises on the final timeout cycle -> SEND, no err.
//  T5 rst mid-SEND at bit 40 -> next cycle SDO=0, sdo_valid=0, no frame_done.
//     A following full frame completes correctly.
//  T6 core_done=1 during START only -> ignored; block stays in WAIT until a later core_done.
//     Also: two back-to-back frames with CS held high give two frame_done pulses.

Source files
------------

// File: rtl/aes_spi_slave_if_if.sv
// rtl/aes_spi_slave_if_if.sv - SPI link and AES core handshake bundle for aes_spi_slave_if.
interface aes_spi_slave_if_if #(
  parameter int DATA_W = 128
);
  logic              CS;
  logic              SDI;
  logic              SDO;
  logic              sdo_valid;
  logic              frame_done;
  logic              err;
  logic              core_start;
  logic [DATA_W-1:0] core_block;
  logic [DATA_W-1:0] core_result;
  logic              core_done;

  modport slave (
    input  CS, SDI, core_result, core_done,
    output SDO, sdo_valid, frame_done, err, core_start, core_block
  );

  modport master (
    output CS, SDI, core_result, core_done,
    input  SDO, sdo_valid, frame_done, err, core_start, core_block
  );
endinterface

// File: rtl/aes_spi_slave_if.sv
// rtl/aes_spi_slave_if.sv - SPI responder: shift a block in, run it through the AES core, shift the result out.
module aes_spi_slave_if #(
  parameter int DATA_W  = 128,
  parameter int TIMEOUT = 64
) (
  input logic                 clk,
  input logic                 rst,
  aes_spi_slave_if_if.slave   bus
);
  localparam int CW = $clog2(DATA_W);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);
  localparam logic [TW-1:0] LAST_TO  = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, RECV, START, WAIT, SEND} state_t;

  state_t              state;
  logic [CW-1:0]       bit_cnt;
  logic [TW-1:0]       to_cnt;
  // Shift registers hold only the bits not yet on the wire, so every bit is consumed.
  logic [DATA_W-2:0]   shift_in;
  logic [DATA_W-2:0]   shift_out;
  logic [DATA_W-1:0]   in_next;
  logic [DATA_W-1:0]   out_next;
  logic                sdo_q;
  logic                sdo_valid_q;
  logic                frame_done_q;
  logic                err_q;
  logic                core_start_q;
  logic [DATA_W-1:0]   core_block_q;

  assign in_next  = {shift_in, bus.SDI};
  assign out_next = {shift_out, 1'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      to_cnt       <= '0;
      shift_in     <= '0;
      shift_out    <= '0;
      sdo_q        <= 1'b0;
      sdo_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      core_start_q <= 1'b0;
      core_block_q <= '0;
    end else begin
      core_start_q <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.CS) begin
            shift_in <= in_next[DATA_W-2:0];
            bit_cnt  <= CW'(1);
            state    <= RECV;
          end
        end
        RECV: begin
          if (!bus.CS) begin
            bit_cnt <= '0;
            state   <= IDLE;
          end else begin
            shift_in <= in_next[DATA_W-2:0];
            if (bit_cnt == LAST_BIT) begin
              // Block and start become visible together so the core sees a complete block.
              core_block_q <= in_next;
              core_start_q <= 1'b1;
              state        <= START;
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
        end
        START: begin
          to_cnt  <= '0;
          bit_cnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (bus.core_done) begin
            shift_out   <= bus.core_result[DATA_W-2:0];
            sdo_q       <= bus.core_result[DATA_W-1];
            sdo_valid_q <= 1'b1;
            bit_cnt     <= '0;
            state       <= SEND;
          end else if (to_cnt == LAST_TO) begin
            err_q <= 1'b1;
            state <= IDLE;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        SEND: begin
          if (bit_cnt == LAST_BIT) begin
            sdo_q        <= 1'b0;
            sdo_valid_q  <= 1'b0;
            frame_done_q <= 1'b1;
            bit_cnt      <= '0;
            state        <= IDLE;
          end else begin
            sdo_q     <= out_next[DATA_W-1];
            shift_out <= out_next[DATA_W-2:0];
            bit_cnt   <= bit_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.SDO        = sdo_q;
  assign bus.sdo_valid  = sdo_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.err        = err_q;
  assign bus.core_start = core_start_q;
  assign bus.core_block = core_block_q;
endmodule

// File: tb/tb_aes_spi_slave_if.sv
// tb/tb_aes_spi_slave_if.sv - directed bench for aes_spi_slave_if with a fixed-latency AES core model.
module tb_aes_spi_slave_if;
  localparam int DW = 128;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst;

  aes_spi_slave_if_if #(.DATA_W(DW)) bus ();

  aes_spi_slave_if #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int overlap_cnt = 0;

  // Pulse counters, sampled just after each rising edge so negedge checks see settled counts.
  always @(posedge clk) begin
    #1;
    if (bus.core_start === 1'b1) start_cnt++;
    if (bus.frame_done === 1'b1) done_cnt++;
    if (bus.err === 1'b1) err_cnt++;
    if (int'(bus.core_start === 1'b1) + int'(bus.frame_done === 1'b1) + int'(bus.err === 1'b1) > 1)
      overlap_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

  task automatic shift_block(input logic [DW-1:0] blk, input logic cs_hold, input string tag);
    int s0;
    s0 = start_cnt;
    for (int i = 0; i < DW; i++) begin
      bus.CS  = 1'b1;
      bus.SDI = blk[DW-1-i];
      @(negedge clk);
    end
    n_cmp++;
    if (bus.core_start !== 1'b1 || start_cnt - s0 !== 1) begin
      n_bad++;
      $display("FAIL %s core_start: got %b (pulses %0d) want 1 (pulses 1)", tag, bus.core_start, start_cnt - s0);
    end
    n_cmp++;
    if (bus.core_block !== blk) begin
      n_bad++;
      $display("FAIL %s core_block: got %h want %h", tag, bus.core_block, blk);
    end
    bus.CS  = cs_hold;
    bus.SDI = 1'b0;
  endtask

  task automatic core_reply(input int lat, input logic [DW-1:0] res, input logic done_in_start, input string tag);
    logic seen;
    seen = 1'b0;
    bus.core_done   = done_in_start;
    bus.core_result = ~res;
    @(negedge clk);
    for (int j = 0; j < lat; j++) begin
      bus.core_done = 1'b0;
      seen = seen | bus.SDO | bus.sdo_valid | bus.err | bus.core_start;
      @(negedge clk);
    end
    seen = seen | bus.SDO | bus.sdo_valid | bus.err;
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL %s wait_quiet: got activity %b want 0", tag, seen);
    end
    bus.core_done   = 1'b1;
    bus.core_result = res;
    @(negedge clk);
    bus.core_done   = 1'b0;
    bus.core_result = ~res;
  endtask

  task automatic collect(input logic [DW-1:0] res, input string tag);
    logic [DW-1:0] rx;
    int nv;
    int d0;
    rx = '0;
    nv = 0;
    d0 = done_cnt;
    for (int k = 0; k < DW; k++) begin
      rx[DW-1-k] = bus.SDO;
      if (bus.sdo_valid === 1'b1) nv++;
      @(negedge clk);
    end
    n_cmp++;
    if (rx !== res) begin
      n_bad++;
      $display("FAIL %s sdo_data: got %h want %h", tag, rx, res);
    end
    n_cmp++;
    if (nv !== DW) begin
      n_bad++;
      $display("FAIL %s sdo_valid_cycles: got %0d want %0d", tag, nv, DW);
    end
    n_cmp++;
    if (bus.frame_done !== 1'b1 || done_cnt - d0 !== 1 || bus.sdo_valid !== 1'b0 || bus.SDO !== 1'b0) begin
      n_bad++;
      $display("FAIL %s frame_end: got done=%b pulses=%0d valid=%b sdo=%b want 1 1 0 0",
               tag, bus.frame_done, done_cnt - d0, bus.sdo_valid, bus.SDO);
    end
  endtask

  task automatic full_frame(input logic [DW-1:0] blk, input logic [DW-1:0] res, input int lat,
                            input logic cs_hold, input string tag);
    shift_block(blk, cs_hold, tag);
    core_reply(lat, res, 1'b0, tag);
    collect(res, tag);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.CS = 1'b1;
    bus.SDI = 1'b1;
    bus.core_done = 1'b0;
    bus.core_result = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.SDO, bus.sdo_valid, bus.frame_done, bus.err, bus.core_start} !== 5'b0 || start_cnt !== 0) begin
      n_bad++;
      $display("FAIL reset outputs: got %b starts %0d want 00000 starts 0",
               {bus.SDO, bus.sdo_valid, bus.frame_done, bus.err, bus.core_start}, start_cnt);
    end
    n_cmp++;
    if (bus.core_block !== '0) begin
      n_bad++;
      $display("FAIL reset core_block: got %h want 0", bus.core_block);
    end
    rst = 1'b0;
    bus.CS = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fips();
    full_frame(128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 10, 1'b0, "fips");
    @(negedge clk);
  endtask

  task automatic test_cs_abort();
    logic [DW-1:0] blk;
    int s0;
    blk = 128'hfedcba98765432100123456789abcdef;
    s0 = start_cnt;
    for (int i = 0; i < 61; i++) begin
      bus.CS  = 1'b1;
      bus.SDI = blk[DW-1-i];
      @(negedge clk);
    end
    bus.CS = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (start_cnt !== s0 || bus.sdo_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL cs_abort no_start: got starts %0d valid %b want 0 0", start_cnt - s0, bus.sdo_valid);
    end
    full_frame(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 128'h3925841d02dc09fbdc118597196a0b32, 3, 1'b0, "after_abort");
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int e0;
    int s0;
    logic seen;
    e0 = err_cnt;
    seen = 1'b0;
    shift_block(128'h3243f6a8885a308d313198a2e0370734, 1'b0, "timeout");
    s0 = start_cnt;
    bus.core_done = 1'b0;
    repeat (TO) begin
      @(negedge clk);
      seen = seen | bus.SDO | bus.sdo_valid | bus.err;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout early_activity: got %b want 0", seen);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.err !== 1'b1 || err_cnt - e0 !== 1 || bus.SDO !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout err_pulse: got err=%b pulses=%0d sdo=%b want 1 1 0", bus.err, err_cnt - e0, bus.SDO);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.err !== 1'b0 || bus.sdo_valid !== 1'b0 || start_cnt !== s0) begin
      n_bad++;
      $display("FAIL timeout after: got err=%b valid=%b starts=%0d want 0 0 0", bus.err, bus.sdo_valid, start_cnt - s0);
    end
    e0 = err_cnt;
    full_frame(128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32, TO - 1, 1'b0, "late_done");
    n_cmp++;
    if (err_cnt !== e0) begin
      n_bad++;
      $display("FAIL late_done no_err: got %0d err pulses want 0", err_cnt - e0);
    end
    @(negedge clk);
  endtask

  task automatic test_rst_mid_send();
    logic [DW-1:0] res;
    int d0;
    res = 128'ha5a5a5a5_5a5a5a5a_c3c3c3c3_3c3c3c3c;
    shift_block(128'h0123456789abcdeffedcba9876543210, 1'b0, "rst_send");
    core_reply(5, res, 1'b0, "rst_send");
    repeat (40) @(negedge clk);
    n_cmp++;
    if (bus.SDO !== res[DW-1-40] || bus.sdo_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_send bit40: got sdo=%b valid=%b want %b 1", bus.SDO, bus.sdo_valid, res[DW-1-40]);
    end
    d0 = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.SDO !== 1'b0 || bus.sdo_valid !== 1'b0 || bus.frame_done !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_send cleared: got sdo=%b valid=%b done=%b want 0 0 0", bus.SDO, bus.sdo_valid, bus.frame_done);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (done_cnt !== d0 || bus.sdo_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_send no_done: got pulses=%0d valid=%b want 0 0", done_cnt - d0, bus.sdo_valid);
    end
    full_frame(128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 2, 1'b0, "after_rst");
    @(negedge clk);
  endtask

  task automatic test_done_in_start();
    shift_block(128'h1111222233334444aaaabbbbccccdddd, 1'b0, "done_start");
    core_reply(6, 128'h8ea2b7ca516745bfeafc49904b496089, 1'b1, "done_start");
    collect(128'h8ea2b7ca516745bfeafc49904b496089, "done_start");
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = done_cnt;
    full_frame(128'h00000000000000000000000000000001, 128'h80000000000000000000000000000000, 4, 1'b1, "b2b_a");
    full_frame(128'hffffffffffffffffffffffffffffffff, 128'h0123456789abcdef0123456789abcdef, 7, 1'b1, "b2b_b");
    bus.CS = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (done_cnt - d0 !== 2) begin
      n_bad++;
      $display("FAIL b2b done_pulses: got %0d want 2", done_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_fips();
    test_cs_abort();
    test_timeout();
    test_rst_mid_send();
    test_done_in_start();
    test_back_to_back();
    n_cmp++;
    if (overlap_cnt !== 0) begin
      n_bad++;
      $display("FAIL pulse_overlap: got %0d cycles want 0", overlap_cnt);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
